aes_key_sched_ctrl: RTL and testbench

Sequencer that runs AES-128 key expansion from a 128-bit cipher key using a single shared, externally instanced combinational S-box. SubWord is done one byte per cycle through the S-box port. The block stores all 11 round keys and serves them to the decryptor datapath through a combinational read port, in forward or reverse (decryption) order. It sits between key load and the round datapath and owns the S-box while busy.

---
 rtl/aes_key_sched_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: one S-box byte per cycle, 11 stored round keys, fwd/rev read port.
// Optional macro AES_KEY_ZEROIZE_EN adds a synchronous zeroize input.
module aes_key_sched_ctrl #(
  parameter bit DEC_ORDER = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         ready,
  output logic [3:0]   sb_x,
  output logic [3:0]   sb_y,
  input  logic [7:0]   sb_out,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NUM_RK   = 11;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned BSEL_W   = 2;
  localparam int unsigned LAST_RND = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } state_e;

  function automatic logic [BYTE_W-1:0] rcon(input logic [IDX_W-1:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Byte b of RotWord(w), byte 0 being the most significant.
  function automatic logic [BYTE_W-1:0] rot_byte(input logic [WORD_W-1:0] w,
                                                 input logic [BSEL_W-1:0] b);
    logic [WORD_W-1:0] t;
    t = {w[23:0], w[31:24]};
    case (b)
      2'd0:    rot_byte = t[31:24];
      2'd1:    rot_byte = t[23:16];
      2'd2:    rot_byte = t[15:8];
      default: rot_byte = t[7:0];
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    round_q, round_d;
  logic [BSEL_W-1:0]   byte_q,  byte_d;
  logic [KEY_W-1:0]    w_q,     w_d;
  logic [WORD_W-1:0]   sub_q,   sub_d;
  logic [KEY_W-1:0]    rk_q [NUM_RK];
  logic [KEY_W-1:0]    rk_d [NUM_RK];
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                ready_q, ready_d;
  logic [BYTE_W-1:0]   sb_q,    sb_d;

  logic [WORD_W-1:0]   temp_w, w0_n, w1_n, w2_n, w3_n;

  assign temp_w = sub_q ^ {rcon(round_q), 24'h0};
  assign w0_n   = w_q[127:96] ^ temp_w;
  assign w1_n   = w_q[95:64]  ^ w0_n;
  assign w2_n   = w_q[63:32]  ^ w1_n;
  assign w3_n   = w_q[31:0]   ^ w2_n;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    byte_d  = byte_q;
    w_d     = w_q;
    sub_d   = sub_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rk_d[0] = key_in;
          w_d     = key_in;
          round_d = IDX_W'(1);
          byte_d  = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        case (byte_q)
          2'd0:    sub_d[31:24] = sb_out;
          2'd1:    sub_d[23:16] = sb_out;
          2'd2:    sub_d[15:8]  = sb_out;
          default: sub_d[7:0]   = sb_out;
        endcase
        byte_d = byte_q + BSEL_W'(1);
        if (byte_q == BSEL_W'(3)) begin
          state_d = MIX;
        end
      end
      MIX: begin
        rk_d[round_q] = {w0_n, w1_n, w2_n, w3_n};
        w_d           = {w0_n, w1_n, w2_n, w3_n};
        if (round_q == IDX_W'(LAST_RND)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          round_d = round_q + IDX_W'(1);
          byte_d  = '0;
          state_d = SUB;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AES_KEY_ZEROIZE_EN
    // Zeroize overrides start and any expansion in flight.
    if (zeroize) begin
      state_d = IDLE;
      round_d = '0;
      byte_d  = '0;
      w_d     = '0;
      sub_d   = '0;
      rk_d    = '{default: '0};
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ready_d = 1'b0;
    end
`endif

    // Present next cycle's S-box byte so the port is driven straight from a flop.
    sb_d = (state_d == SUB) ? rot_byte(w_d[31:0], byte_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      byte_q  <= '0;
      w_q     <= '0;
      sub_q   <= '0;
      rk_q    <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      byte_q  <= byte_d;
      w_q     <= w_d;
      sub_q   <= sub_d;
      rk_q    <= rk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      sb_q    <= sb_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = ready_q;
  assign sb_x  = sb_q[7:4];
  assign sb_y  = sb_q[3:0];

  // Round-key read port; decryption order reverses the index.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= IDX_W'(LAST_RND)) begin
      if (DEC_ORDER) begin
        rd_key = rk_q[IDX_W'(LAST_RND) - rd_idx];
      end else begin
        rd_key = rk_q[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: forward and reverse-order instances against a FIPS-197 style key-expansion model.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_idx = '0;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  logic         busy0, done0, ready0, busy1, done1, ready1;
  logic [3:0]   sbx0, sby0, sbx1, sby1;
  logic [7:0]   sbo0, sbo1;
  logic [127:0] rk0, rk1;

  logic [7:0]   sbox_tbl [256];
  logic [127:0] exp_rk [11];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign sbo0 = sbox_tbl[{sbx0, sby0}];
  assign sbo1 = sbox_tbl[{sbx1, sby1}];

  aes_key_sched_ctrl #(.DEC_ORDER(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_in(key_in), .busy(busy0), .done(done0), .ready(ready0),
    .sb_x(sbx0), .sb_y(sby0), .sb_out(sbo0), .rd_idx(rd_idx), .rd_key(rk0)
  );

  aes_key_sched_ctrl #(.DEC_ORDER(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .start(start), .key_in(key_in), .busy(busy1), .done(done1), .ready(ready1),
    .sb_x(sbx1), .sb_y(sby1), .sb_out(sbo1), .rd_idx(rd_idx), .rd_key(rk1)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Textbook AES-128 key expansion over 44 words.
  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; done_k stays -1 if it never comes.
  task automatic wait_done(input int k0, output int done_k, output int busy_cnt);
    done_k   = -1;
    busy_cnt = 0;
    for (int k = k0 + 1; k <= k0 + 80; k++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        done_k = k;
        break;
      end
      if (busy0) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if ({busy0, done0, ready0} !== 3'b000) begin n_err++; $display("FAIL reset_flags fwd got %b exp 000", {busy0, done0, ready0}); end
    n_cmp++; if ({busy1, done1, ready1} !== 3'b000) begin n_err++; $display("FAIL reset_flags rev got %b exp 000", {busy1, done1, ready1}); end
    n_cmp++; if ({sbx0, sby0} !== 8'h00) begin n_err++; $display("FAIL reset_sb got %h exp 00", {sbx0, sby0}); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== 128'h0) begin n_err++; $display("FAIL reset_key fwd idx=%0d got %h exp 0", i, rk0); end
      n_cmp++; if (rk1 !== 128'h0) begin n_err++; $display("FAIL reset_key rev idx=%0d got %h exp 0", i, rk1); end
    end
  endtask

  task automatic test_fips();
    logic [127:0] key;
    logic [7:0]   sb_log [5];
    logic [7:0]   sb_exp [5];
    int           done_k, busy_cnt, bc0;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sb_exp[0] = 8'hcf; sb_exp[1] = 8'h4f; sb_exp[2] = 8'h3c; sb_exp[3] = 8'h09; sb_exp[4] = 8'h00;
    model_expand(key);
    do_start(key);
    bc0 = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      sb_log[k] = {sbx0, sby0};
      if (busy0) bc0++;
    end
    wait_done(4, done_k, busy_cnt);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (sb_log[k] !== sb_exp[k]) begin n_err++; $display("FAIL fips_sb step=%0d got %h exp %h", k, sb_log[k], sb_exp[k]); end
    end
    n_cmp++; if (done_k !== 50) begin n_err++; $display("FAIL fips_done_edge got E0+%0d exp E0+51 (sampled after E0+50)", done_k + 1); end
    n_cmp++; if (bc0 + busy_cnt !== 50) begin n_err++; $display("FAIL fips_busy_cycles got %0d exp 50", bc0 + busy_cnt); end
    n_cmp++; if (ready0 !== 1'b1 || done1 !== 1'b1) begin n_err++; $display("FAIL fips_ready_at_done got ready=%b done_rev=%b exp 1 1", ready0, done1); end
    @(posedge clk); #1;
    n_cmp++; if ({done0, ready0, busy0} !== 3'b010) begin n_err++; $display("FAIL fips_done_pulse got done/ready/busy=%b exp 010", {done0, ready0, busy0}); end
    n_cmp++; if ({sbx0, sby0} !== 8'h00) begin n_err++; $display("FAIL fips_sb_idle got %h exp 00", {sbx0, sby0}); end
    rd_idx = 4'd1; #1;
    n_cmp++; if (rk0 !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_err++; $display("FAIL fips_rk1 got %h exp a0fafe1788542cb123a339392a6c7605", rk0); end
    rd_idx = 4'd10; #1;
    n_cmp++; if (rk0 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL fips_rk10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk0); end
    rd_idx = 4'd0; #1;
    n_cmp++; if (rk1 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_err++; $display("FAIL fips_rev_idx0 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk1); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== (i <= 10 ? exp_rk[i] : 128'h0)) begin n_err++; $display("FAIL fips_key fwd idx=%0d got %h exp %h", i, rk0, (i <= 10 ? exp_rk[i] : 128'h0)); end
      n_cmp++; if (rk1 !== (i <= 10 ? exp_rk[10-i] : 128'h0)) begin n_err++; $display("FAIL fips_key rev idx=%0d got %h exp %h", i, rk1, (i <= 10 ? exp_rk[10-i] : 128'h0)); end
    end
  endtask

  task automatic test_zero_key();
    int done_k, busy_cnt;
    do_start(128'h0);
    wait_done(0, done_k, busy_cnt);
    n_cmp++; if (done_k !== 50) begin n_err++; $display("FAIL zero_done got %0d exp 50", done_k); end
    rd_idx = 4'd1; #1;
    n_cmp++; if (rk0 !== 128'h62636363626363636263636362636363) begin n_err++; $display("FAIL zero_rk1 got %h exp 62636363626363636263636362636363", rk0); end
    rd_idx = 4'd0; #1;
    n_cmp++; if (rk0 !== 128'h0) begin n_err++; $display("FAIL zero_rk0 got %h exp 0", rk0); end
    rd_idx = 4'd10; #1;
    n_cmp++; if (rk1 !== 128'h0) begin n_err++; $display("FAIL zero_rev_idx10 got %h exp 0", rk1); end
    rd_idx = 4'd9; #1;
    n_cmp++; if (rk1 !== 128'h62636363626363636263636362636363) begin n_err++; $display("FAIL zero_rev_idx9 got %h exp 62636363626363636263636362636363", rk1); end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] k1, k2;
    int           done_k, busy_cnt;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    model_expand(k1);
    do_start(k1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    key_in = k2;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10, done_k, busy_cnt);
    n_cmp++; if (done_k !== 50) begin n_err++; $display("FAIL busy_start_done got %0d exp 50", done_k); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== (i <= 10 ? exp_rk[i] : 128'h0)) begin n_err++; $display("FAIL busy_start_key fwd idx=%0d got %h exp %h", i, rk0, (i <= 10 ? exp_rk[i] : 128'h0)); end
      n_cmp++; if (rk1 !== (i <= 10 ? exp_rk[10-i] : 128'h0)) begin n_err++; $display("FAIL busy_start_key rev idx=%0d got %h exp %h", i, rk1, (i <= 10 ? exp_rk[10-i] : 128'h0)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    int           done_k, busy_cnt;
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    n_cmp++; if (ready0 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_before got %b exp 1", ready0); end
    do_start(k);
    n_cmp++; if ({ready0, busy0} !== 2'b01) begin n_err++; $display("FAIL b2b_ready_drop got ready/busy=%b exp 01", {ready0, busy0}); end
    wait_done(0, done_k, busy_cnt);
    n_cmp++; if (done_k !== 50) begin n_err++; $display("FAIL b2b_done got %0d exp 50", done_k); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== exp_rk[i]) begin n_err++; $display("FAIL b2b_key fwd idx=%0d got %h exp %h", i, rk0, exp_rk[i]); end
      n_cmp++; if (rk1 !== exp_rk[10-i]) begin n_err++; $display("FAIL b2b_key rev idx=%0d got %h exp %h", i, rk1, exp_rk[10-i]); end
    end
  endtask

  task automatic test_random();
    logic [127:0] k;
    int           done_k, busy_cnt;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      do_start(k);
      wait_done(0, done_k, busy_cnt);
      n_cmp++; if (done_k !== 50) begin n_err++; $display("FAIL rand_done run=%0d got %0d exp 50", n, done_k); end
      for (int i = 0; i < 16; i++) begin
        rd_idx = 4'(i); #1;
        n_cmp++; if (rk0 !== (i <= 10 ? exp_rk[i] : 128'h0)) begin n_err++; $display("FAIL rand_key fwd run=%0d idx=%0d got %h exp %h", n, i, rk0, (i <= 10 ? exp_rk[i] : 128'h0)); end
        n_cmp++; if (rk1 !== (i <= 10 ? exp_rk[10-i] : 128'h0)) begin n_err++; $display("FAIL rand_key rev run=%0d idx=%0d got %h exp %h", n, i, rk1, (i <= 10 ? exp_rk[10-i] : 128'h0)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k;
    int           done_k, busy_cnt;
    do_start({$urandom, $urandom, $urandom, $urandom});
    repeat (23) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy0, ready0, done0, busy1} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b exp 0000", {busy0, ready0, done0, busy1}); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #0.25;
      n_cmp++; if (rk0 !== 128'h0 || rk1 !== 128'h0) begin n_err++; $display("FAIL rst_mid_key idx=%0d got %h / %h exp 0", i, rk0, rk1); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    do_start(k);
    wait_done(0, done_k, busy_cnt);
    n_cmp++; if (done_k !== 50 || busy_cnt !== 49) begin n_err++; $display("FAIL rst_mid_rerun got done=%0d busy=%0d exp 50 49", done_k, busy_cnt); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== exp_rk[i]) begin n_err++; $display("FAIL rst_mid_key2 idx=%0d got %h exp %h", i, rk0, exp_rk[i]); end
    end
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    int done_k, busy_cnt;
    do_start({$urandom, $urandom, $urandom, $urandom});
    repeat (29) @(posedge clk);
    @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    n_cmp++; if ({busy0, ready0, done0} !== 3'b000) begin n_err++; $display("FAIL zeroize_flags got %b exp 000", {busy0, ready0, done0}); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk0 !== 128'h0) begin n_err++; $display("FAIL zeroize_key idx=%0d got %h exp 0", i, rk0); end
    end
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_done(0, done_k, busy_cnt);
    @(negedge clk);
    zeroize = 1'b1;
    start   = 1'b1;
    key_in  = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    zeroize = 1'b0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({busy0, ready0, done0} !== 3'b000) begin n_err++; $display("FAIL zeroize_start got %b exp 000", {busy0, ready0, done0}); end
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i); #1;
      n_cmp++; if (rk1 !== 128'h0) begin n_err++; $display("FAIL zeroize_start_key idx=%0d got %h exp 0", i, rk1); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_f(8'(i));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_fips();
    test_zero_key();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
